// File: rtl/find_win_pkg.sv
// Shared types for the multi-cycle Connect-4 scanner.
//   win_t        : result encoding (none / red / green / tie)
//   dir_t        : direction of a winning run, measured from its anchor cell
//   scan_state_t : scanner FSM states
//   clog2_min1   : index width helper that never returns 0
package find_win_pkg;

  typedef enum logic [1:0] {
    NO_WIN    = 2'b00,
    RED_WIN   = 2'b01,
    GREEN_WIN = 2'b10,
    TIE       = 2'b11
  } win_t;

  typedef enum logic [1:0] {
    DIR_H       = 2'd0,
    DIR_V       = 2'd1,
    DIR_DIAG_UP = 2'd2,
    DIR_DIAG_DN = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // A 1-row or 1-column board still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/win_row_check.sv
// Combinational evaluation of every anchor cell in one board row.
// Ports:
//   red, green    : full board snapshots, [row][col]
//   row           : row being evaluated
//   hit           : some window anchored in this row is fully owned by one player
//   color         : owner of the selected window (RED_WIN / GREEN_WIN)
//   col, dir      : anchor column and direction of the selected window
//   row_has_empty : some cell in this row is owned by nobody
//   row_conflict  : some cell in this row is owned by both players
module win_row_check
  import find_win_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int WIN_LEN = 4,
  localparam int RW     = clog2_min1(ROWS),
  localparam int CW     = clog2_min1(COLS)
) (
  input  logic [ROWS-1:0][COLS-1:0] red,
  input  logic [ROWS-1:0][COLS-1:0] green,
  input  logic [RW-1:0]             row,
  output logic                      hit,
  output win_t                      color,
  output logic [CW-1:0]             col,
  output dir_t                      dir,
  output logic                      row_has_empty,
  output logic                      row_conflict
);

  // True when all WIN_LEN cells from (r,c) along direction d are set in b.
  // Cells that fall off the board make the window fail.
  function automatic logic run_at(input logic [ROWS-1:0][COLS-1:0] b,
                                  input int r, input int c, input int d);
    logic ok;
    int   rr;
    int   cc;
    ok = 1'b1;
    for (int k = 0; k < WIN_LEN; k++) begin
      rr = r;
      cc = c + k;
      case (d)
        1: begin rr = r + k; cc = c; end
        2: rr = r + k;
        3: rr = r - k;
        default: ;
      endcase
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
      else if (!b[rr[RW-1:0]][cc[CW-1:0]]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Walk from the lowest-priority candidate to the highest so the final
  // write wins: lowest column, then H > V > DIAG_UP > DIAG_DN, then green.
  always_comb begin
    hit           = 1'b0;
    color         = NO_WIN;
    col           = '0;
    dir           = DIR_H;
    row_has_empty = 1'b0;
    row_conflict  = 1'b0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!(red[row][c[CW-1:0]] | green[row][c[CW-1:0]])) row_has_empty = 1'b1;
      if (red[row][c[CW-1:0]] & green[row][c[CW-1:0]])    row_conflict  = 1'b1;
      for (int d = 3; d >= 0; d--) begin
        if (run_at(red, int'(row), c, d)) begin
          hit   = 1'b1;
          color = RED_WIN;
          col   = CW'(c);
          dir   = dir_t'(d[1:0]);
        end
        if (run_at(green, int'(row), c, d)) begin
          hit   = 1'b1;
          color = GREEN_WIN;
          col   = CW'(c);
          dir   = dir_t'(d[1:0]);
        end
      end
    end
  end

endmodule

// File: rtl/find_win_scan.sv
// Multi-cycle Connect-4 win detector: snapshots both boards on start and
// checks one row per clock, stopping at the first row holding a win.
// Ports:
//   Clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : scan request, honoured only in IDLE
//   red, green          : live occupancy boards, [row][col]
//   busy                : high while rows are being scanned
//   done                : one-cycle pulse, result outputs valid
//   win                 : 00 none, 01 red, 10 green, 11 tie
//   win_row/win_col     : anchor of the winning run
//   win_dir             : 0 H, 1 V, 2 DIAG_UP, 3 DIAG_DN
//   err                 : some scanned cell was owned by both players
//
// state | meaning
// IDLE  | waiting for start; results from last scan held
// SCAN  | evaluating snapshot row row_q
// DONE  | result registered, done pulse
module find_win_scan
  import find_win_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int WIN_LEN = 4,
  localparam int RW     = clog2_min1(ROWS),
  localparam int CW     = clog2_min1(COLS)
) (
  input  logic                      Clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROWS-1:0][COLS-1:0] red,
  input  logic [ROWS-1:0][COLS-1:0] green,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                win,
  output logic [RW-1:0]             win_row,
  output logic [CW-1:0]             win_col,
  output logic [1:0]                win_dir,
  output logic                      err
);

  scan_state_t              state_q, state_d;
  logic [RW-1:0]            row_q;
  logic [ROWS-1:0][COLS-1:0] snap_red, snap_green;
  logic                     err_acc_q, empty_acc_q;

  logic                     hit, row_has_empty, row_conflict;
  win_t                     hit_color;
  logic [CW-1:0]            hit_col;
  dir_t                     hit_dir;
  logic                     row_last;

  win_row_check #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_row_check (
    .red           (snap_red),
    .green         (snap_green),
    .row           (row_q),
    .hit           (hit),
    .color         (hit_color),
    .col           (hit_col),
    .dir           (hit_dir),
    .row_has_empty (row_has_empty),
    .row_conflict  (row_conflict)
  );

  assign row_last = (row_q == RW'(ROWS - 1));
  assign busy     = (state_q == SCAN);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (hit || row_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      snap_red    <= '0;
      snap_green  <= '0;
      err_acc_q   <= 1'b0;
      empty_acc_q <= 1'b0;
      win         <= NO_WIN;
      win_row     <= '0;
      win_col     <= '0;
      win_dir     <= DIR_H;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_red    <= red;
            snap_green  <= green;
            row_q       <= '0;
            err_acc_q   <= 1'b0;
            empty_acc_q <= 1'b0;
          end
        end
        SCAN: begin
          err_acc_q   <= err_acc_q | row_conflict;
          empty_acc_q <= empty_acc_q | row_has_empty;
          if (hit) begin
            win     <= hit_color;
            win_row <= row_q;
            win_col <= hit_col;
            win_dir <= hit_dir;
            err     <= err_acc_q | row_conflict;
          end else if (row_last) begin
            // Tie needs every cell of every row occupied, this row included.
            win     <= (empty_acc_q | row_has_empty) ? NO_WIN : TIE;
            win_row <= '0;
            win_col <= '0;
            win_dir <= DIR_H;
            err     <= err_acc_q | row_conflict;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_win_scan.sv
module tb_find_win_scan;

  logic               Clock;
  logic               reset;
  logic               start, start5;
  logic [15:0][15:0]  red, green, red5, green5;
  logic               busy, done, err, busy5, done5, err5;
  logic [1:0]         win, win_dir, win5, win_dir5;
  logic [3:0]         win_row, win_col, win_row5, win_col5;

  int n_checks = 0;
  int n_errors = 0;
  int lat, busy_cyc, done_cnt, cnt;

  find_win_scan #(.ROWS(16), .COLS(16), .WIN_LEN(4)) dut (
    .Clock(Clock), .reset(reset), .start(start), .red(red), .green(green),
    .busy(busy), .done(done), .win(win), .win_row(win_row), .win_col(win_col),
    .win_dir(win_dir), .err(err)
  );

  find_win_scan #(.ROWS(16), .COLS(16), .WIN_LEN(5)) dut5 (
    .Clock(Clock), .reset(reset), .start(start5), .red(red5), .green(green5),
    .busy(busy5), .done(done5), .win(win5), .win_row(win_row5), .win_col(win_col5),
    .win_dir(win_dir5), .err(err5)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_boards();
    red = '0; green = '0; red5 = '0; green5 = '0;
  endtask

  // One-cycle start pulse; lat = number of edges after E0 until done seen.
  task automatic do_scan(input bit sel);
    @(negedge Clock);
    if (sel) start5 = 1'b1; else start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; start5 = 1'b0;
    lat = 0; busy_cyc = 0; done_cnt = 0;
    if (sel ? busy5 : busy) busy_cyc++;
    while (!(sel ? done5 : done) && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
      if (sel ? busy5 : busy) busy_cyc++;
    end
    if (sel ? done5 : done) done_cnt++;
    @(posedge Clock); #1;
    if (sel ? done5 : done) done_cnt++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start5 = 1'b0;
    clear_boards();
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_win", win, 0);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    check("rst_dir", win_dir, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // Empty board: full scan
    do_scan(0);
    check("empty_lat", lat, 16);
    check("empty_busy", busy_cyc, 16);
    check("empty_done_cnt", done_cnt, 1);
    check("empty_win", win, 0);
    check("empty_err", err, 0);

    // Red horizontal in row 5
    clear_boards();
    for (int c = 3; c <= 6; c++) red[5][c] = 1'b1;
    do_scan(0);
    check("h_lat", lat, 6);
    check("h_win", win, 1);
    check("h_row", win_row, 5);
    check("h_col", win_col, 3);
    check("h_dir", win_dir, 0);
    check("h_done_cnt", done_cnt, 1);

    // Green vertical found before red horizontal further down
    clear_boards();
    for (int r = 2; r <= 5; r++) green[r][9] = 1'b1;
    for (int c = 0; c <= 3; c++) red[10][c] = 1'b1;
    do_scan(0);
    check("v_lat", lat, 3);
    check("v_win", win, 2);
    check("v_row", win_row, 2);
    check("v_col", win_col, 9);
    check("v_dir", win_dir, 1);

    // Green diagonal up
    clear_boards();
    for (int k = 0; k < 4; k++) green[12+k][3+k] = 1'b1;
    do_scan(0);
    check("up_lat", lat, 13);
    check("up_win", win, 2);
    check("up_row", win_row, 12);
    check("up_col", win_col, 3);
    check("up_dir", win_dir, 2);

    // Red diagonal down, anchored on the last row
    clear_boards();
    for (int k = 0; k < 4; k++) red[15-k][k] = 1'b1;
    do_scan(0);
    check("dn_lat", lat, 16);
    check("dn_win", win, 1);
    check("dn_row", win_row, 15);
    check("dn_col", win_col, 0);
    check("dn_dir", win_dir, 3);

    // Full board with no run of four
    clear_boards();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        red[r][c]   = (((c >> 1) + r) % 2) == 1;
        green[r][c] = !((((c >> 1) + r) % 2) == 1);
      end
    do_scan(0);
    check("tie_lat", lat, 16);
    check("tie_win", win, 3);
    check("tie_err", err, 0);
    red[7][7] = 1'b0; green[7][7] = 1'b0;
    do_scan(0);
    check("hole_lat", lat, 16);
    check("hole_win", win, 0);

    // Conflicting cell
    clear_boards();
    red[0][0] = 1'b1; green[0][0] = 1'b1;
    do_scan(0);
    check("err_flag", err, 1);
    check("err_win", win, 0);

    // Snapshot: boards change and start stays high during the scan
    clear_boards();
    for (int c = 3; c <= 6; c++) red[5][c] = 1'b1;
    @(negedge Clock); start = 1'b1;
    @(posedge Clock); #1;
    red = '0; green = '1;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    start = 1'b0;
    check("snap_lat", lat, 6);
    check("snap_win", win, 1);
    check("snap_row", win_row, 5);
    check("snap_err", err, 0);
    cnt = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (done || busy) cnt++;
    end
    check("snap_no_rescan", cnt, 0);

    // Reset in the middle of a scan
    clear_boards();
    @(negedge Clock); start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge Clock); #1;
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_win", win, 0);
    check("mid_rst_row", win_row, 0);
    check("mid_rst_col", win_col, 0);
    cnt = 0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (done) cnt++;
    end
    check("mid_no_done", cnt, 0);

    // WIN_LEN = 5 instance
    clear_boards();
    for (int c = 0; c <= 3; c++) red5[4][c] = 1'b1;
    do_scan(1);
    check("w5_four_lat", lat, 16);
    check("w5_four_win", win5, 0);
    red5[4][4] = 1'b1;
    do_scan(1);
    check("w5_five_lat", lat, 5);
    check("w5_five_win", win5, 1);
    check("w5_five_row", win_row5, 4);
    check("w5_five_col", win_col5, 0);
    check("w5_five_dir", win_dir5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
